// File: rtl/adc_sequencer.sv
// Scan sequencer for a 16-bit SPI ADC master: walks the masked channels, triggers
// one frame per channel, captures each sample into a per-channel result register.
`timescale 1ns/1ps
module adc_sequencer #(
    parameter int         RES_W   = 12,
    parameter int         TIMEOUT = 4000000,
    parameter logic [4:0] CMD_HI  = 5'b11000
) (
    input  logic             clk,
    input  logic             resn,
    input  logic             enable,
    input  logic [7:0]       chanMask,
    input  logic [15:0]      interval,
    output logic             trig,
    output logic [15:0]      wrData,
    input  logic [15:0]      rdData,
    input  logic             ss,
    input  logic [2:0]       rdAddr,
    input  logic             rdStrobe,
    output logic [RES_W-1:0] result,
    output logic [7:0]       newData,
    output logic             scanDone,
    output logic             timeoutErr
);
    localparam int            TW       = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SELECT, S_START, S_BUSY, S_CAPTURE, S_NEXT, S_WAIT
    } state_t;

    state_t           state_q;
    logic             ss_meta_q, ss_s_q;
    logic [1:0]       settle_q;
    logic [2:0]       chan_q;
    logic             trig_q, scan_done_q, timeout_q;
    logic [15:0]      wr_q;
    logic [15:0]      cnt_q;
    logic [TW-1:0]    tmo_q;
    logic [7:0]       new_q;
    logic [RES_W-1:0] res_q [8];

    logic [2:0]       sel_chan;
    logic [3:0]       above;
    logic             unused_rd;

    // Lowest masked channel at or after s, wrapping 7 -> 0.
    function automatic logic [2:0] first_from(input logic [7:0] m, input logic [2:0] s);
        logic [2:0] r;
        logic [2:0] idx;
        r = s;
        for (int i = 7; i >= 0; i--) begin
            idx = s + 3'(i);
            if (m[idx]) r = idx;
        end
        return r;
    endfunction

    // {found, index} of the lowest masked channel strictly above s, no wrap.
    function automatic logic [3:0] next_above(input logic [7:0] m, input logic [2:0] s);
        logic [3:0] r;
        r = 4'b0000;
        for (int i = 7; i >= 0; i--) begin
            if ((3'(i) > s) && m[i]) r = {1'b1, 3'(i)};
        end
        return r;
    endfunction

    assign sel_chan   = first_from(chanMask, chan_q);
    assign above      = next_above(chanMask, chan_q);
    assign unused_rd  = ^rdData;

    assign trig       = trig_q;
    assign wrData     = wr_q;
    assign newData    = new_q;
    assign scanDone   = scan_done_q;
    assign timeoutErr = timeout_q;
    assign result     = res_q[rdAddr];

    always_ff @(posedge clk or posedge resn) begin
        if (resn) begin
            state_q     <= S_IDLE;
            ss_meta_q   <= 1'b1;
            ss_s_q      <= 1'b1;
            settle_q    <= 2'b00;
            chan_q      <= 3'd0;
            trig_q      <= 1'b0;
            scan_done_q <= 1'b0;
            timeout_q   <= 1'b0;
            wr_q        <= 16'h0000;
            cnt_q       <= 16'h0000;
            tmo_q       <= '0;
            new_q       <= 8'h00;
            for (int i = 0; i < 8; i++) res_q[i] <= '0;
        end else begin
            ss_meta_q   <= ss;
            ss_s_q      <= ss_meta_q;
            // The synchroniser resets to "idle high"; do not trust it until real
            // ss has propagated through both flops, so an in-flight frame drains.
            settle_q    <= {settle_q[0], 1'b1};
            scan_done_q <= 1'b0;
            if (rdStrobe) new_q[rdAddr] <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    trig_q <= 1'b0;
                    if (enable && (chanMask != 8'h00) && ss_s_q && settle_q[1])
                        state_q <= S_SELECT;
                end
                S_SELECT: begin
                    if (chanMask != 8'h00) begin
                        chan_q  <= sel_chan;
                        wr_q    <= {CMD_HI, sel_chan, 8'h00};
                        trig_q  <= 1'b1;
                        tmo_q   <= '0;
                        state_q <= S_START;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_START, S_BUSY: begin
                    if (tmo_q == TMO_LAST) begin
                        timeout_q <= 1'b1;
                        trig_q    <= 1'b0;
                        state_q   <= S_IDLE;
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
                        if (state_q == S_START && !ss_s_q) begin
                            trig_q  <= 1'b0;
                            state_q <= S_BUSY;
                        end else if (state_q == S_BUSY && ss_s_q) begin
                            state_q <= S_CAPTURE;
                        end
                    end
                end
                S_CAPTURE: begin
                    res_q[chan_q] <= rdData[RES_W-1:0];
                    new_q[chan_q] <= 1'b1;
                    state_q       <= S_NEXT;
                end
                S_NEXT: begin
                    if (above[3]) begin
                        chan_q  <= above[2:0];
                        state_q <= enable ? S_SELECT : S_IDLE;
                    end else begin
                        scan_done_q <= 1'b1;
                        chan_q      <= 3'd0;
                        if (!enable)
                            state_q <= S_IDLE;
                        else if (interval == 16'h0000)
                            state_q <= S_SELECT;
                        else begin
                            cnt_q   <= interval - 16'd1;
                            state_q <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt_q == 16'h0000)
                        state_q <= enable ? S_SELECT : S_IDLE;
                    else
                        cnt_q <= cnt_q - 16'd1;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_adc_sequencer.sv
// Directed + randomized bench for adc_sequencer with a behavioural SPI master/ADC stand-in.
`timescale 1ns/1ps
module tb_adc_sequencer;
    localparam int RES_W = 12;
    localparam int TMO   = 100;
    localparam int FRAME = 6;

    logic             clk = 1'b0;
    logic             resn, enable, ss, rdStrobe;
    logic [7:0]       chanMask;
    logic [15:0]      interval, rdData;
    logic [2:0]       rdAddr;
    logic             trig, scanDone, timeoutErr;
    logic [15:0]      wrData;
    logic [RES_W-1:0] result;
    logic [7:0]       newData;

    logic [15:0] spi_data [8];
    int          n_cmp = 0;
    int          n_err = 0;

    int          cyc = 0;
    int          scan_cnt = 0;
    int          trig_cyc [$];
    int          scan_cyc [$];
    logic [15:0] wr_log [$];
    logic        trig_prev = 1'b0;

    always #5 clk = ~clk;

    adc_sequencer #(.RES_W(RES_W), .TIMEOUT(TMO), .CMD_HI(5'b11000)) dut (
        .clk(clk), .resn(resn), .enable(enable), .chanMask(chanMask),
        .interval(interval), .trig(trig), .wrData(wrData), .rdData(rdData),
        .ss(ss), .rdAddr(rdAddr), .rdStrobe(rdStrobe), .result(result),
        .newData(newData), .scanDone(scanDone), .timeoutErr(timeoutErr)
    );

    // Trigger/scan event log, sampled mid-cycle.
    always @(negedge clk) begin
        cyc       <= cyc + 1;
        trig_prev <= trig;
        if (trig && !trig_prev) begin
            trig_cyc.push_back(cyc);
            wr_log.push_back(wrData);
        end
        if (scanDone) begin
            scan_cnt <= scan_cnt + 1;
            scan_cyc.push_back(cyc);
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_trig();
        int n;
        n = 0;
        while (!trig && n < 300) begin
            tick(1);
            n++;
        end
        check("trig_wait", 32'(trig), 32'd1);
    endtask

    // One SPI frame as the master would run it: ss falls shortly after trig,
    // stays low FRAME cycles, then rdData holds the sample for the command channel.
    task automatic do_frame(input bit drop_en);
        logic [2:0] ch;
        wait_trig();
        if (!trig) return;
        ch = wrData[10:8];
        tick(2);
        ss     = 1'b0;
        rdData = spi_data[ch];
        if (drop_en) enable = 1'b0;
        tick(FRAME);
        ss = 1'b1;
    endtask

    task automatic clear_new();
        for (int a = 0; a < 8; a++) begin
            rdAddr   = 3'(a);
            rdStrobe = 1'b1;
            tick(1);
        end
        rdStrobe = 1'b0;
    endtask

    initial begin
        int          base, sbase, scan0, k, hi, cnt;
        logic [7:0]  mask, nd_before;
        logic [15:0] exp_wr [$];

        resn = 1'b1; enable = 1'b0; ss = 1'b1; rdStrobe = 1'b0;
        chanMask = 8'h00; interval = 16'h0000; rdData = 16'h0000; rdAddr = 3'd0;
        for (int i = 0; i < 8; i++) spi_data[i] = 16'h0000;
        tick(3);
        check("rst_trig", 32'(trig), 32'd0);
        check("rst_wrData", 32'(wrData), 32'h0000);
        check("rst_newData", 32'(newData), 32'h00);
        check("rst_scanDone", 32'(scanDone), 32'd0);
        check("rst_timeoutErr", 32'(timeoutErr), 32'd0);
        resn = 1'b0;
        tick(2);

        // Two back-to-back scans of channels 0 and 2.
        spi_data[0] = 16'h0ABC; spi_data[2] = 16'h0123;
        chanMask = 8'h05; interval = 16'd0; enable = 1'b1;
        base = wr_log.size(); scan0 = scan_cnt;
        for (int j = 0; j < 4; j++) do_frame(j == 3);
        tick(20);
        check("t1_ntrig", 32'(wr_log.size() - base), 32'd4);
        if (wr_log.size() - base == 4) begin
            check("t1_wr0", 32'(wr_log[base]),   32'hC000);
            check("t1_wr1", 32'(wr_log[base+1]), 32'hC200);
            check("t1_wr2", 32'(wr_log[base+2]), 32'hC000);
            check("t1_wr3", 32'(wr_log[base+3]), 32'hC200);
        end
        check("t1_scans", 32'(scan_cnt - scan0), 32'd2);
        check("t1_newData", 32'(newData), 32'h05);
        rdAddr = 3'd0; #1 check("t1_res0", 32'(result), 32'hABC);
        rdAddr = 3'd2; #1 check("t1_res2", 32'(result), 32'h123);

        // Empty mask: nothing may trigger.
        chanMask = 8'h00; enable = 1'b1; hi = 0; base = wr_log.size();
        for (int i = 0; i < 10000; i++) begin
            tick(1);
            if (trig) hi++;
        end
        check("idle_trig_cycles", 32'(hi), 32'd0);
        check("idle_trig_rises", 32'(wr_log.size() - base), 32'd0);
        enable = 1'b0;
        tick(5);

        // Randomized masks and samples against the scan-order model.
        for (int it = 0; it < 6; it++) begin
            mask = 8'($urandom_range(1, 255));
            for (int c = 0; c < 8; c++) spi_data[c] = 16'($urandom);
            clear_new();
            check("rnd_clear", 32'(newData), 32'h00);
            exp_wr.delete();
            for (int c = 0; c < 8; c++) if (mask[c]) exp_wr.push_back(16'hC000 | 16'(c << 8));
            k = exp_wr.size();
            base = wr_log.size(); scan0 = scan_cnt;
            chanMask = mask; interval = 16'($urandom_range(0, 20)); enable = 1'b1;
            for (int j = 0; j < k; j++) do_frame(j == k - 1);
            tick(30);
            check("rnd_ntrig", 32'(wr_log.size() - base), 32'(k));
            if (wr_log.size() - base == k)
                for (int j = 0; j < k; j++) check("rnd_wr", 32'(wr_log[base+j]), 32'(exp_wr[j]));
            check("rnd_scans", 32'(scan_cnt - scan0), 32'd1);
            check("rnd_newData", 32'(newData), 32'(mask));
            for (int c = 0; c < 8; c++) if (mask[c]) begin
                rdAddr = 3'(c); #1;
                check("rnd_result", 32'(result), 32'(spi_data[c][RES_W-1:0]));
            end
        end
        check("rnd_no_timeout", 32'(timeoutErr), 32'd0);

        // Interval: the next trig rises interval+1 cycles after scanDone
        // (scanDone marks the first WAIT cycle, then interval WAIT cycles elapse
        // minus one, then SELECT, then trig).
        spi_data[7] = 16'($urandom);
        chanMask = 8'h80; interval = 16'd50; enable = 1'b1;
        base = wr_log.size(); sbase = scan_cyc.size();
        do_frame(1'b0);
        do_frame(1'b1);
        tick(20);
        check("intv_ntrig", 32'(wr_log.size() - base), 32'd2);
        if (wr_log.size() - base == 2 && scan_cyc.size() > sbase) begin
            check("intv_wr0", 32'(wr_log[base]),   32'hC700);
            check("intv_wr1", 32'(wr_log[base+1]), 32'hC700);
            check("intv_gap", 32'(trig_cyc[base+1] - scan_cyc[sbase]), 32'd51);
        end
        interval = 16'd0;

        // Read race: strobe channel 2 in its CAPTURE cycle.
        clear_new();
        chanMask = 8'h04; enable = 1'b1;
        wait_trig();
        check("race_wr", 32'(wrData), 32'hC200);
        enable = 1'b0;
        tick(2); ss = 1'b0; rdData = 16'h0123;
        tick(FRAME); ss = 1'b1;
        tick(3); rdAddr = 3'd2; rdStrobe = 1'b1;
        tick(1); rdStrobe = 1'b0;
        check("race_capture_wins", 32'(newData[2]), 32'd1);
        tick(5); rdStrobe = 1'b1;
        tick(1); rdStrobe = 1'b0;
        check("race_cleared", 32'(newData[2]), 32'd0);
        check("race_result", 32'(result), 32'h123);

        // Timeout: ss never falls.
        chanMask = 8'h01; enable = 1'b1;
        wait_trig();
        enable = 1'b0; nd_before = newData; cnt = 0;
        while (trig && cnt < 1000) begin
            cnt++;
            tick(1);
        end
        check("tmo_trig_cycles", 32'(cnt), 32'(TMO));
        check("tmo_err", 32'(timeoutErr), 32'd1);
        check("tmo_newData", 32'(newData), 32'(nd_before));
        hi = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (trig) hi++;
        end
        check("tmo_idle", 32'(hi), 32'd0);

        // Reset while BUSY with ss low.
        spi_data[0] = 16'h0F5A;
        chanMask = 8'h01; enable = 1'b1;
        wait_trig();
        tick(2); ss = 1'b0;
        tick(6);
        #2 resn = 1'b1;
        #1;
        check("mrst_trig", 32'(trig), 32'd0);
        check("mrst_wrData", 32'(wrData), 32'h0000);
        check("mrst_newData", 32'(newData), 32'h00);
        check("mrst_scanDone", 32'(scanDone), 32'd0);
        check("mrst_timeoutErr", 32'(timeoutErr), 32'd0);
        for (int a = 0; a < 8; a++) begin
            rdAddr = 3'(a); #1;
            check("mrst_result", 32'(result), 32'h000);
        end
        @(posedge clk); #1 resn = 1'b0;
        hi = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (trig) hi++;
        end
        check("mrst_hold_ss_low", 32'(hi), 32'd0);
        ss = 1'b1;
        tick(1); check("mrst_ss_high1", 32'(trig), 32'd0);
        tick(1); check("mrst_ss_high2", 32'(trig), 32'd0);
        do_frame(1'b1);
        tick(20);
        check("mrst_resume_newData", 32'(newData), 32'h01);
        rdAddr = 3'd0; #1 check("mrst_resume_result", 32'(result), 32'hF5A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
